pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Game sequencer for the pong top level. It owns the left/right score counters that feed the score display and gates the ball with a serve/play/point/game-over state machine. Timing is counted in frames, derived from rising edges of the vsync output of the sync generator. Miss events come from the ball/paddle logic; start comes from the player button.

Parameters:
WIN_SCORE, 11, score value that ends the game (1..15)
SERVE_DELAY, 60, frames spent in SERVE_WAIT before launching the ball (0..255)
POINT_HOLD, 30, frames spent in POINT after a score (0..255)

Ports:
clk  in  1  pixel clock, single clock domain
reset  in  1  asynchronous, active-low reset (0 = reset)
vsync  in  1  vertical sync level from the sync generator, synchronous to clk
start  in  1  start/coin button, synchronous level
miss_left  in  1  ball exited past the left paddle (single-cycle pulse)
miss_right  in  1  ball exited past the right paddle (single-cycle pulse)
left_score  out  4  left player score, drives the score display
right_score  out  4  right player score, drives the score display
ball_enable  out  1  ball motion/visibility enable
serve  out  1  one-cycle pulse: load ball at centre and launch
serve_dir  out  1  launch direction: 0 = toward left, 1 = toward right
game_over  out  1  high in GAME_OVER
state  out  3  current state encoding, for debug

Behaviour:
- Reset (reset=0, asynchronous): state=ATTRACT(0); scores=0; ball_enable=0; serve=0; serve_dir=0; game_over=0; frame counter=0; edge-detect registers cleared.
- Frame tick: tick = vsync & ~vsync_q, where vsync_q is vsync registered. Exactly one tick per vsync rising edge; a vsync already high at reset release does not produce a tick.
- Start edge: start_p = start & ~start_q. A held button produces a single event.
- Frame counter is 8 bits. Entering a timed state loads N, where N = max(param, 1). The counter decrements on each tick, and the exit transition occurs on the tick that takes it to 0, i.e. the N-th tick after entry.
- States (encoding): ATTRACT=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4.
- ATTRACT: ball_enable=0. On start_p: clear both scores, serve_dir<=0, load SERVE_DELAY, go to SERVE_WAIT.
- SERVE_WAIT: ball_enable=0. On the exit tick: serve=1 for exactly one cycle (the cycle after the tick), go to PLAY. ball_enable becomes 1 in the same cycle serve is high.
- PLAY: ball_enable=1.
  - miss_left: right_score+1, serve_dir<=0 (serve toward the conceding player).
  - miss_right: left_score+1, serve_dir<=1.
  - If the incremented score equals WIN_SCORE, go to GAME_OVER; otherwise load POINT_HOLD and go to POINT.
  - Score and state update one cycle after the miss is sampled.
- POINT: ball_enable=0. On the exit tick: load SERVE_DELAY, go to SERVE_WAIT.
- GAME_OVER: ball_enable=0, game_over=1, scores frozen and displayed. On start_p: same action as from ATTRACT.
- Simultaneous miss_left and miss_right in PLAY: miss_left wins and miss_right is dropped.
- Misses outside PLAY are ignored.
- start_p outside ATTRACT/GAME_OVER is ignored (no restart mid-game).
- Scores saturate at 15. No wrap is possible when WIN_SCORE ≤ 15.
- A tick and a miss arriving in the same PLAY cycle: the miss is processed normally; the tick has no effect in PLAY.
- Reset asserted mid-game returns everything to the reset values immediately; no serve pulse is emitted.
- Every output is a registered value, with no combinational path from input to output.

Test Plan:
1. Reset with WIN_SCORE=3, SERVE_DELAY=2, POINT_HOLD=3; pulse start. Required: state=1, scores 0/0. Exactly one serve pulse, in the cycle after the 2nd vsync rising edge; state=2, ball_enable=1, serve_dir=0.
2. In PLAY, pulse miss_left. Required: right_score=1, state=3, ball_enable=0, serve_dir=0. After 3 ticks state=1; after 2 more ticks a serve pulse and state=2.
3. Drive miss_left and miss_right in the same cycle. Required: right_score increments by 1 and left_score is unchanged. Then drive misses with no vsync activity between them. Required: each miss is counted once per PLAY entry; misses arriving in POINT or SERVE_WAIT change nothing.
4. Drive miss_right until left_score=3. Required: state=4, game_over=1, score holds at 3 through further misses and ticks. A start pulse then clears the scores and reaches state=1.
5. Hold start high across the whole game. Required: only one restart; start seen in PLAY has no effect. Hold vsync high at reset release. Required: no tick until vsync falls and rises again.
6. Assert reset (reset=0) during SERVE_WAIT one cycle before the serve pulse is due. Required: no serve pulse, all outputs 0, state=0 immediately without waiting for a clk edge.

Source files
------------

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Game sequencer for the pong top level. Holds the left/right
//               score counters, gates the ball through an
//               ATTRACT / SERVE_WAIT / PLAY / POINT / GAME_OVER state machine,
//               and times the serve delay and point hold in video frames.
//               Frames are counted on rising edges of vsync.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   pixel clock, single clock domain
//   reset        in   asynchronous active-low reset (0 = reset)
//   vsync        in   vertical sync level, synchronous to clk
//   start        in   start/coin button level
//   miss_left    in   ball left the field past the left paddle (pulse)
//   miss_right   in   ball left the field past the right paddle (pulse)
//   left_score   out  left player score [3:0]
//   right_score  out  right player score [3:0]
//   ball_enable  out  ball motion/visibility enable
//   serve        out  one-cycle pulse: centre and launch the ball
//   serve_dir    out  launch direction, 0 = toward left, 1 = toward right
//   game_over    out  high while in GAME_OVER
//   state        out  current state encoding [2:0], for debug
// ============================================================================
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE   = 11,  // 1..15
  parameter int unsigned SERVE_DELAY = 60,  // frames, 0..255
  parameter int unsigned POINT_HOLD  = 30   // frames, 0..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       ball_enable,
  output logic       serve,
  output logic       serve_dir,
  output logic       game_over,
  output logic [2:0] state
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // A zero frame count is treated as one frame so every timed state still
  // waits for a real frame boundary before leaving.
  localparam logic [3:0] c_win_score  = WIN_SCORE[3:0];
  localparam logic [7:0] c_serve_load = (SERVE_DELAY == 0) ? 8'd1 : SERVE_DELAY[7:0];
  localparam logic [7:0] c_hold_load  = (POINT_HOLD == 0)  ? 8'd1 : POINT_HOLD[7:0];

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_next;

  logic       r_vsync_q;
  logic       r_edge_valid;
  logic       r_start_q;

  logic [7:0] r_frame_cnt;
  logic [7:0] w_frame_cnt_next;
  logic [3:0] r_left_score;
  logic [3:0] w_left_next;
  logic [3:0] r_right_score;
  logic [3:0] w_right_next;
  logic       r_serve_dir;
  logic       w_serve_dir_next;
  logic       r_serve;
  logic       w_serve_next;
  logic       r_ball_enable;
  logic       r_game_over;

  logic       w_tick;
  logic       w_start_p;
  logic [3:0] w_left_inc;
  logic [3:0] w_right_inc;

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
  // r_edge_valid stays low for the first clock after reset release, so a
  // vsync that is already high when reset lifts is taken as the current
  // level rather than as a new rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsync_q    <= 1'b0;
      r_edge_valid <= 1'b0;
      r_start_q    <= 1'b0;
    end else begin
      r_vsync_q    <= vsync;
      r_edge_valid <= 1'b1;
      r_start_q    <= start;
    end
  end

  assign w_tick    = vsync & ~r_vsync_q & r_edge_valid;
  assign w_start_p = start & ~r_start_q;

  // Saturating score increments
  assign w_left_inc  = (r_left_score  == 4'hF) ? 4'hF : r_left_score  + 4'd1;
  assign w_right_inc = (r_right_score == 4'hF) ? 4'hF : r_right_score + 4'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ATTRACT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_left_next      = r_left_score;
    w_right_next     = r_right_score;
    w_serve_dir_next = r_serve_dir;
    w_serve_next     = 1'b0;

    case (r_state)
      ST_ATTRACT, ST_GAME_OVER: begin
        if (w_start_p) begin
          w_left_next      = 4'd0;
          w_right_next     = 4'd0;
          w_serve_dir_next = 1'b0;
          w_frame_cnt_next = c_serve_load;
          w_state_next     = ST_SERVE_WAIT;
        end
      end

      ST_SERVE_WAIT: begin
        if (w_tick) begin
          // Leave on the tick that brings the count to zero.
          if (r_frame_cnt <= 8'd1) begin
            w_frame_cnt_next = 8'd0;
            w_serve_next     = 1'b1;
            w_state_next     = ST_PLAY;
          end else begin
            w_frame_cnt_next = r_frame_cnt - 8'd1;
          end
        end
      end

      ST_PLAY: begin
        // The next serve goes toward the player who just conceded.
        // A simultaneous miss on both sides is scored as miss_left only.
        if (miss_left) begin
          w_right_next     = w_right_inc;
          w_serve_dir_next = 1'b0;
          if (w_right_inc == c_win_score) begin
            w_state_next = ST_GAME_OVER;
          end else begin
            w_frame_cnt_next = c_hold_load;
            w_state_next     = ST_POINT;
          end
        end else if (miss_right) begin
          w_left_next      = w_left_inc;
          w_serve_dir_next = 1'b1;
          if (w_left_inc == c_win_score) begin
            w_state_next = ST_GAME_OVER;
          end else begin
            w_frame_cnt_next = c_hold_load;
            w_state_next     = ST_POINT;
          end
        end
      end

      ST_POINT: begin
        if (w_tick) begin
          if (r_frame_cnt <= 8'd1) begin
            w_frame_cnt_next = c_serve_load;
            w_state_next     = ST_SERVE_WAIT;
          end else begin
            w_frame_cnt_next = r_frame_cnt - 8'd1;
          end
        end
      end

      default: begin
        w_state_next = ST_ATTRACT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered datapath and outputs
  // --------------------------------------------------------------------------
  // ball_enable and game_over are decoded from the next state so they change
  // in the same cycle the state register does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt   <= 8'd0;
      r_left_score  <= 4'd0;
      r_right_score <= 4'd0;
      r_serve_dir   <= 1'b0;
      r_serve       <= 1'b0;
      r_ball_enable <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_frame_cnt   <= w_frame_cnt_next;
      r_left_score  <= w_left_next;
      r_right_score <= w_right_next;
      r_serve_dir   <= w_serve_dir_next;
      r_serve       <= w_serve_next;
      r_ball_enable <= (w_state_next == ST_PLAY);
      r_game_over   <= (w_state_next == ST_GAME_OVER);
    end
  end

  assign left_score  = r_left_score;
  assign right_score = r_right_score;
  assign ball_enable = r_ball_enable;
  assign serve       = r_serve;
  assign serve_dir   = r_serve_dir;
  assign game_over   = r_game_over;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Self-checking bench for pong_game_ctrl. A frame-counting
//               reference model predicts every output each cycle; directed
//               checks pin the key moments of each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

  localparam int P_WIN = 3;
  localparam int P_SD  = 2;
  localparam int P_PH  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b0;
  logic       start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic       ball_enable;
  logic       serve;
  logic       serve_dir;
  logic       game_over;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl #(
    .WIN_SCORE  (P_WIN),
    .SERVE_DELAY(P_SD),
    .POINT_HOLD (P_PH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .start      (start),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .left_score (left_score),
    .right_score(right_score),
    .ball_enable(ball_enable),
    .serve      (serve),
    .serve_dir  (serve_dir),
    .game_over  (game_over),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: phases numbered as the debug encoding, frames counted
  // upward from entry and compared to the requested frame count.
  // --------------------------------------------------------------------------
  int m_phase = 0;
  int m_ticks = 0;
  int m_l = 0;
  int m_r = 0;
  int m_dir = 0;
  int m_serve = 0;
  int m_prev_v = 1;   // level before release counts as "high": no edge yet
  int m_prev_s = 0;
  int m_tk;
  int m_sp;

  function automatic int frames(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_ticks = 0; m_l = 0; m_r = 0; m_dir = 0; m_serve = 0;
      m_prev_v = 1; m_prev_s = 0;
    end else begin
      m_tk = (vsync && m_prev_v == 0) ? 1 : 0;
      m_sp = (start && m_prev_s == 0) ? 1 : 0;
      m_prev_v = vsync ? 1 : 0;
      m_prev_s = start ? 1 : 0;
      m_serve = 0;
      case (m_phase)
        0, 4: if (m_sp == 1) begin
          m_l = 0; m_r = 0; m_dir = 0; m_ticks = 0; m_phase = 1;
        end
        1: if (m_tk == 1) begin
          m_ticks++;
          if (m_ticks == frames(P_SD)) begin m_phase = 2; m_serve = 1; end
        end
        2: begin
          if (miss_left) begin
            m_r = (m_r < 15) ? m_r + 1 : 15; m_dir = 0;
            if (m_r == P_WIN) m_phase = 4; else begin m_phase = 3; m_ticks = 0; end
          end else if (miss_right) begin
            m_l = (m_l < 15) ? m_l + 1 : 15; m_dir = 1;
            if (m_l == P_WIN) m_phase = 4; else begin m_phase = 3; m_ticks = 0; end
          end
        end
        3: if (m_tk == 1) begin
          m_ticks++;
          if (m_ticks == frames(P_PH)) begin m_phase = 1; m_ticks = 0; end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_state",       32'(state),       32'(m_phase));
    chk("cyc_left_score",  32'(left_score),  32'(m_l));
    chk("cyc_right_score", 32'(right_score), 32'(m_r));
    chk("cyc_serve",       32'(serve),       32'(m_serve));
    chk("cyc_serve_dir",   32'(serve_dir),   32'(m_dir));
    chk("cyc_ball_enable", 32'(ball_enable), (m_phase == 2) ? 32'd1 : 32'd0);
    chk("cyc_game_over",   32'(game_over),   (m_phase == 4) ? 32'd1 : 32'd0);
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic miss(input logic l, input logic r);
    @(negedge clk) begin miss_left = l; miss_right = r; end
    @(negedge clk) begin miss_left = 1'b0; miss_right = 1'b0; end
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    cyc(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_scores", 32'({left_score, right_score}), 0);
    chk("rst_outs", 32'({ball_enable, serve, serve_dir, game_over}), 0);
    reset = 1'b1;
    cyc(2);

    // Start, serve after the second frame
    pulse_start();
    chk("t1_state_wait", 32'(state), 1);
    chk("t1_scores", 32'({left_score, right_score}), 0);
    tick();
    chk("t1_no_serve_yet", 32'(serve), 0);
    tick();
    chk("t1_serve", 32'(serve), 1);
    chk("t1_play", 32'(state), 2);
    chk("t1_ball_en", 32'(ball_enable), 1);
    chk("t1_dir", 32'(serve_dir), 0);
    cyc(1);
    chk("t1_serve_one_cycle", 32'(serve), 0);

    // Miss left: right scores, point hold, then serve
    miss(1'b1, 1'b0);
    chk("t2_right", 32'(right_score), 1);
    chk("t2_point", 32'(state), 3);
    chk("t2_ball_off", 32'(ball_enable), 0);
    ticks(3);
    chk("t2_wait", 32'(state), 1);
    ticks(2);
    chk("t2_serve", 32'(serve), 1);
    chk("t2_play", 32'(state), 2);

    // Both misses together, misses outside PLAY
    miss(1'b1, 1'b1);
    chk("t3_right", 32'(right_score), 2);
    chk("t3_left", 32'(left_score), 0);
    miss(1'b1, 1'b0);
    chk("t3_point_ignore", 32'(right_score), 2);
    ticks(3);
    chk("t3_wait", 32'(state), 1);
    miss(1'b0, 1'b1);
    chk("t3_wait_ignore", 32'(left_score), 0);
    ticks(2);
    chk("t3_play", 32'(state), 2);
    miss(1'b0, 1'b1);
    chk("t3_left1", 32'(left_score), 1);
    chk("t3_dir1", 32'(serve_dir), 1);
    miss(1'b0, 1'b1);
    chk("t3_once", 32'(left_score), 1);
    ticks(5);

    // Left reaches the winning score
    miss(1'b0, 1'b1);
    chk("t4_left2", 32'(left_score), 2);
    ticks(5);
    miss(1'b0, 1'b1);
    chk("t4_left3", 32'(left_score), 3);
    chk("t4_over", 32'(state), 4);
    chk("t4_go", 32'(game_over), 1);
    miss(1'b0, 1'b1);
    ticks(2);
    chk("t4_frozen", 32'(left_score), 3);
    chk("t4_still_over", 32'(state), 4);
    pulse_start();
    chk("t4_restart", 32'(state), 1);
    chk("t4_cleared", 32'({left_score, right_score}), 0);

    // Start in PLAY ignored; held start restarts only once
    ticks(2);
    pulse_start();
    chk("t5_play_kept", 32'(state), 2);
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      miss(1'b0, 1'b1);
      if (i < 2) ticks(5);
    end
    chk("t5_over", 32'(state), 4);
    cyc(5);
    chk("t5_held_no_restart", 32'(state), 4);
    @(negedge clk) start = 1'b0;
    pulse_start();
    chk("t5_restart", 32'(state), 1);

    // vsync high across reset release: no tick until it falls and rises
    @(negedge clk) begin reset = 1'b0; vsync = 1'b1; end
    cyc(2);
    reset = 1'b1;
    cyc(3);
    pulse_start();
    cyc(3);
    chk("t5_vs_wait", 32'(state), 1);
    vsync = 1'b0;
    tick();
    chk("t5_vs_one_tick", 32'(state), 1);
    tick();
    chk("t5_vs_serve", 32'(serve), 1);

    // Reset one cycle before a due serve
    miss(1'b1, 1'b0);
    ticks(3);
    tick();
    chk("t6_wait", 32'(state), 1);
    @(negedge clk) vsync = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("t6_async_state", 32'(state), 0);
    chk("t6_async_outs", 32'({left_score, right_score, ball_enable, serve, serve_dir, game_over}), 0);
    @(negedge clk) vsync = 1'b0;
    chk("t6_no_serve", 32'(serve), 0);
    cyc(2);
    reset = 1'b1;
    cyc(2);
    chk("t6_attract", 32'(state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
